// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM bank controller.
package sram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 3;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-latency shift register; each stage holds its payload while no valid passes through,
// so the last stage doubles as the held read-data output.
module sram_rd_pipe #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk0,
  input  logic             rst0_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LAT-1:0]   valid_q;
  logic [WIDTH-1:0] data_q [LAT];

  // NOTE: non-blocking assignments let every stage sample its predecessor's old value,
  // giving a true shift regardless of statement order.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/sram_bank_ctrl.sv
// Single-port SRAM bank controller: clears memory after reset, then serves masked
// writes and fixed-latency reads. Define SRAM_PARITY_EN for per-byte even parity.
module sram_bank_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_LAT   = 1
) (
  input  logic                    clk0,
  input  logic                    rst0_n,
  input  logic                    csb0,
  input  logic                    web0,
  input  logic [DATA_WIDTH/8-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH-1:0]   din0,
  output logic                    ready0,
  output logic [DATA_WIDTH-1:0]   dout0,
  output logic                    dvalid0,
  output logic                    init_done0
`ifdef SRAM_PARITY_EN
  ,
  output logic                    perr0,
  input  logic                    perr_inj0
`endif
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int NBYTES    = DATA_WIDTH / 8;
`ifdef SRAM_PARITY_EN
  localparam int PIPE_W = DATA_WIDTH + 1;
`else
  localparam int PIPE_W = DATA_WIDTH;
`endif

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NBYTES-1:0]       mem_wmask;
  logic                    rd_req;
  logic [PIPE_W-1:0]       rd_payload;
  logic [PIPE_W-1:0]       pipe_data;

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q    <= ST_INIT;
      clr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      // Saturates at the last word so the clear never wraps back to 0.
      if (state_q == ST_INIT && clr_addr_q != '1) clr_addr_q <= clr_addr_q + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    ready0     = 1'b0;
    init_done0 = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr0;
    mem_wdata  = din0;
    mem_wmask  = wmask0;
    rd_req     = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
        mem_wmask = '1;
        if (clr_addr_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        ready0     = 1'b1;
        init_done0 = 1'b1;
        mem_we     = !csb0 && !web0;
        rd_req     = !csb0 && web0;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: the array has no reset; the INIT sweep clears it, which keeps it mappable to RAM.
  always_ff @(posedge clk0) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_wmask[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NBYTES-1:0] par_mem [RAM_DEPTH];
  logic [NBYTES-1:0] wpar;
  logic [NBYTES-1:0] rpar_calc;

  // Stored bit makes each byte-plus-parity even; injection flips it for the written bytes.
  always_comb begin
    wpar      = '0;
    rpar_calc = '0;
    for (int b = 0; b < NBYTES; b++) begin
      wpar[b]      = (^mem_wdata[8*b +: 8]) ^ (perr_inj0 && state_q == ST_IDLE);
      rpar_calc[b] = ^mem[addr0][8*b +: 8];
    end
  end

  always_ff @(posedge clk0) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_wmask[b]) par_mem[mem_waddr][b] <= wpar[b];
      end
    end
  end

  assign rd_payload = {|(rpar_calc ^ par_mem[addr0]), mem[addr0]};
  assign perr0      = dvalid0 && pipe_data[DATA_WIDTH];
`else
  assign rd_payload = mem[addr0];
`endif

  sram_rd_pipe #(
    .WIDTH(PIPE_W),
    .LAT  (READ_LAT)
  ) u_rd_pipe (
    .clk0     (clk0),
    .rst0_n   (rst0_n),
    .in_valid (rd_req),
    .in_data  (rd_payload),
    .out_valid(dvalid0),
    .out_data (pipe_data)
  );

  assign dout0 = pipe_data[DATA_WIDTH-1:0];

endmodule

// File: doc/sram_bank_ctrl.md
SRAM_BANK_CTRL -- requirements
Module: sram_bank_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 5: address width; RAM_DEPTH = 1 << ADDR_WIDTH.
REQ-003 Parameter READ_LAT, default 1: read latency in cycles; legal range 1..3.
REQ-004 clk0  input  1: single clock; all state updates on the rising edge.
REQ-005 rst0_n  input  1: reset, asynchronous and active-low.
REQ-006 csb0  input  1: active-low request strobe.
REQ-007 web0  input  1: 0 = write, 1 = read.
REQ-008 wmask0  input  DATA_WIDTH/8: per-byte write enable; bit i covers din0[8i+7:8i].
REQ-009 addr0  input  ADDR_WIDTH: word address.
REQ-010 din0  input  DATA_WIDTH: write data.
REQ-011 ready0  output  1: controller can accept a request this cycle.
REQ-012 dout0  output  DATA_WIDTH: read data.
REQ-013 dvalid0  output  1: one-cycle pulse marking valid dout0.
REQ-014 init_done0  output  1: high once memory clear is complete.

Function
REQ-015 The FSM SHALL have two states: INIT and IDLE.
REQ-016 INIT SHALL write zero to one word per cycle, address 0 upward, for RAM_DEPTH cycles, then go to IDLE.
REQ-017 In INIT, ready0 and init_done0 SHALL be 0; in IDLE both SHALL be 1.
REQ-018 A request SHALL be accepted on a rising edge where csb0=0 and ready0=1; csb0=0 while ready0=0 SHALL be ignored, not queued.
REQ-019 An accepted write SHALL update, at that edge, only the bytes whose wmask0 bit is 1; wmask0 all-zero SHALL be an accepted no-op.
REQ-020 An accepted read SHALL drive dout0 and pulse dvalid0 exactly READ_LAT cycles after acceptance.
REQ-021 Back-to-back reads SHALL be accepted every cycle, with one dvalid0 pulse per read, in order.
REQ-022 A read accepted the cycle after a write to the same address SHALL return the post-write data.
REQ-023 dout0 SHALL hold its last read value while dvalid0=0.
REQ-024 Address wrap: the counter in INIT SHALL stop at RAM_DEPTH-1 and SHALL NOT wrap.

Reset
REQ-025 Asserting rst0_n=0 SHALL immediately force: state INIT, clear counter 0, ready0=0, init_done0=0, dvalid0=0, dout0=0, read pipeline flushed.
REQ-026 Reset during INIT or with reads in flight SHALL discard the in-flight reads and restart the clear from address 0.

Configuration
REQ-027 Macro SRAM_PARITY_EN SHALL add per-byte even parity: one stored bit per byte, written with its byte and set to 0 by INIT.
REQ-028 With SRAM_PARITY_EN, the block SHALL add ports perr0 (output, 1) and perr_inj0 (input, 1); perr_inj0=1 on a write SHALL store inverted parity for the written bytes.
REQ-029 With SRAM_PARITY_EN, perr0 SHALL pulse together with dvalid0 when any read byte mismatches its parity, and SHALL reset to 0.
REQ-030 Without SRAM_PARITY_EN, no parity storage, perr0 or perr_inj0 SHALL exist.

Structure
REQ-031 Shared package sram_pkg SHALL hold the FSM state enum and the READ_LAT bounds constants.
REQ-032 The read-latency shift register (data, valid, parity error) SHALL be a sub-module, sram_rd_pipe.

Verification
REQ-033 Release reset with ADDR_WIDTH=5 -> ready0=0 for 32 cycles, then ready0=1 and init_done0=1; a read of address 7 -> dout0=0.
REQ-034 Write 0xDEADBEEF to address 3 with wmask0=4'b1111, then write 0x11223344 with wmask0=4'b0101, then read address 3 -> dout0=0xDE22BE44.
REQ-035 READ_LAT=3, reads of addresses 0,1,2 on consecutive cycles -> three dvalid0 pulses on cycles 3,4,5 after the first read, in order.
REQ-036 Write 0xA5A5A5A5 to address 9, read address 9 on the next cycle -> dout0=0xA5A5A5A5.
REQ-037 Assert rst0_n=0 in INIT at counter 10 and with one read in flight -> no dvalid0, and on release the clear restarts at 0 and takes 32 cycles.
REQ-038 SRAM_PARITY_EN: write address 4 with perr_inj0=1, then read address 4 -> perr0=1 with dvalid0; a read of address 5 -> perr0=0.
